fns_dec_seq: RTL
================

Name: fns_dec_seq

Overview:
- Sequencer that time-multiplexes one shared 3-bit FNS group decoder across an NGROUP-group mosaic codeword.
- Accepts a full codeword over a valid/ready handshake and decodes one group per cycle, MSB group first.
- Combines group values by Horner accumulation in base RADIX and returns the binary word over a second valid/ready handshake.
- Sits on the receive side of the CAC link, between the bus capture register and the data sink.

Parameters:
- NGROUP, 4, number of 3-bit FNS groups per codeword (>=2).
- RADIX, 5, number of legal values per group; a group value >= RADIX is illegal.
- OUTW, 10, output data width; must hold RADIX^NGROUP-1 (624 fits in 10 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  codeword offered.
- in_ready  out  1  codeword accepted when in_valid&in_ready.
- codein  in  3*NGROUP  codeword; group i = codein[3i+2:3i], group NGROUP-1 is most significant.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts result.
- dataout  out  OUTW  decoded binary value.
- err  out  1  at least one illegal group seen; qualified by out_valid.
- err_cnt  out  8  error counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=1; out_valid=0; dataout=0; err=0; err_cnt=0; internal group index and accumulator cleared.
- Shared group decoder (combinational): val = c2*3 + c1*2 + c0*1, giving 0..6. Codes 011 and 100 both decode to 3.
- State IDLE:
  - in_ready=1.
  - On accept: latch codein into a shadow register, clear acc and err_acc, set idx=NGROUP-1, go to DECODE.
- State DECODE (one group per cycle):
  - acc <= acc*RADIX + val(group idx).
  - err_acc <= err_acc | (val >= RADIX).
  - While idx > 0: idx decrements.
  - When idx == 0: go to DONE.
  - The arithmetic is sized so that acc never truncates before the final assignment into OUTW bits.
- State DONE:
  - out_valid=1.
  - dataout = err ? 0 : acc.
  - err = err_acc.
  - Outputs hold stable until out_ready.
- Latency: codeword accepted at edge k → out_valid high from edge k+NGROUP+1.
- Back-to-back operation:
  - In DONE, in_ready = out_ready.
  - If out_ready & in_valid: the result retires and the new codeword is latched on the same edge; state goes directly to DECODE and out_valid drops.
  - If out_ready & !in_valid: go to IDLE and drop out_valid.
- in_ready=0 throughout DECODE. codein changes during DECODE are ignored because the shadow register is used.
- Reset mid-operation: the in-flight codeword is discarded and no out_valid is generated.
- Handshake rule: in_valid without in_ready is not a transfer. The upstream block must hold codein stable until the transfer completes.

Optional Feature:
- Macro: FNS_DEC_SEQ_ERRCNT_EN.
- Defined:
  - err_cnt is an 8-bit saturating counter, incremented on each result retired (out_valid&out_ready) with err=1.
  - It sticks at 255 and is cleared only by rst.
- Undefined: err_cnt is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset then idle: rst pulse → in_ready=1, out_valid=0, dataout=0, err=0, err_cnt=0.
- Nominal decode: codein groups (MSB→LSB) 101,010,001,000 with out_ready=1 → dataout=555 (4,2,1,0 base 5), err=0, out_valid exactly 5 cycles after accept.
- Extremes: all groups 000 → dataout=0. All groups 101 → dataout=624. Redundant 011 vs 100 in the LSB group with other groups 000 → both give dataout=3.
- Illegal group: MSB group 110 (value 5), others 000 → err=1, dataout=0. With FNS_DEC_SEQ_ERRCNT_EN defined, err_cnt=1 after retire; 300 such words → err_cnt=255.
- Backpressure and back-to-back: hold out_ready=0 for 3 cycles in DONE → dataout and err stable, in_ready=0. Then out_ready=1 together with a new in_valid → result retires and the new word is accepted on the same edge; the second result follows NGROUP+1 cycles later.
- Reset mid-DECODE: assert rst at idx=2 → immediate IDLE, no out_valid, next codeword decodes correctly.

Source files
------------

// File: rtl/fns_dec_seq_if.sv
// fns_dec_seq_if: handshake bundle for the FNS mosaic decode sequencer.
// Carries the codeword-in valid/ready channel, the result-out valid/ready
// channel and the error status. The master drives codewords and accepts
// results; the slave is the sequencer.
interface fns_dec_seq_if #(
  parameter int NGROUP = 4,
  parameter int OUTW   = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3*NGROUP-1:0]   codein;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUTW-1:0]       dataout;
  logic                  err;
  logic [7:0]            err_cnt;

  modport master (
    output in_valid, codein, out_ready,
    input  in_ready, out_valid, dataout, err, err_cnt
  );

  modport slave (
    input  in_valid, codein, out_ready,
    output in_ready, out_valid, dataout, err, err_cnt
  );
endinterface

// File: rtl/fns_dec_seq.sv
// fns_dec_seq: receive-side sequencer that runs one shared 3-bit FNS group
// decoder across an NGROUP-group codeword, MSB group first, and folds the
// group values together by Horner accumulation in base RADIX.
// Optional macro FNS_DEC_SEQ_ERRCNT_EN enables an 8-bit saturating counter
// of results retired with err set; without it err_cnt is tied to zero.
module fns_dec_seq #(
  parameter int NGROUP = 4,
  parameter int RADIX  = 5,
  parameter int OUTW   = 10
) (
  input  logic           clk,
  input  logic           rst,
  fns_dec_seq_if.slave   bus
);

  // Group values never exceed 6, so the accumulator is sized for the larger
  // of 7 and RADIX per digit; illegal words then cannot wrap it either.
  localparam int RMAX = (RADIX > 7) ? RADIX : 7;
  localparam int ACCW = $clog2(RMAX ** NGROUP) + 1;
  localparam int IDXW = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam int CW   = 3 * NGROUP;

  // RESULT is a single cycle that moves the finished accumulator into the
  // output registers, giving the NGROUP+1 cycle accept-to-valid latency.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESULT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [CW-1:0]     r_shadow;
  logic [ACCW-1:0]   r_acc;
  logic              r_errAcc;
  logic [IDXW-1:0]   r_idx;
  logic [OUTW-1:0]   r_dataout;
  logic              r_err;

  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_capture;
  logic              w_retire;
  logic [2:0]        w_group;
  logic [2:0]        w_val;
  logic              w_illegal;

  assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign bus.out_valid = (r_state == DONE);
  assign bus.dataout   = r_dataout;
  assign bus.err       = r_err;
  assign w_accept      = bus.in_valid && bus.in_ready;

  // Shared group decoder: weights 3,2,1 so codes 011 and 100 both give 3
  always_comb begin
    w_group   = r_shadow[3*r_idx +: 3];
    w_val     = (w_group[2] ? 3'd3 : 3'd0) + (w_group[1] ? 3'd2 : 3'd0) + {2'b00, w_group[0]};
    w_illegal = (int'(w_val) >= RADIX);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        w_step = 1'b1;
        if (r_idx == '0) begin
          w_nextState = RESULT;
        end
      end
      RESULT: begin
        w_capture   = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_retire = 1'b1;
          if (bus.in_valid) begin
            w_load      = 1'b1;
            w_nextState = DECODE;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Shadow capture and Horner accumulation, one group per DECODE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_acc    <= '0;
      r_errAcc <= 1'b0;
      r_idx    <= '0;
    end else if (w_load) begin
      r_shadow <= bus.codein;
      r_acc    <= '0;
      r_errAcc <= 1'b0;
      r_idx    <= IDXW'(NGROUP - 1);
    end else if (w_step) begin
      r_acc    <= r_acc * ACCW'(RADIX) + ACCW'(w_val);
      r_errAcc <= r_errAcc | w_illegal;
      if (r_idx != '0) begin
        r_idx <= r_idx - IDXW'(1);
      end
    end
  end

  // Result registers, held stable through DONE until the sink takes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dataout <= '0;
      r_err     <= 1'b0;
    end else if (w_capture) begin
      r_dataout <= r_errAcc ? '0 : OUTW'(r_acc);
      r_err     <= r_errAcc;
    end
  end

`ifdef FNS_DEC_SEQ_ERRCNT_EN
  logic [7:0] r_errCnt;

  // Count results retired with err set, sticking at 255 until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCnt <= '0;
    end else if (w_retire && r_err && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_errCnt;
`else
  assign bus.err_cnt = 8'd0;
`endif

endmodule
